// File: rtl/muldiv_writeback.sv
// Multi-cycle unsigned multiply/divide unit driving the register file's two write ports.
// Port 1 gets the low product / quotient, port 0 (R0) gets the high product / remainder.
module muldiv_writeback #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-1:0] dest,
  input  logic [WIDTH-1:0]  op_a,
  input  logic [WIDTH-1:0]  op_b,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [ADDR_W-1:0] write_reg,
  output logic [WIDTH-1:0]  write_data,
  output logic [WIDTH-1:0]  r0,
  output logic [1:0]        reg_write
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                op_q, op_d;
  logic [ADDR_W-1:0]   dest_q, dest_d;
  logic [WIDTH-1:0]    b_q, b_d;
  // hi holds the high product / partial remainder, lo the low product / quotient
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;

  logic                busy_d, done_d, dbz_d;
  logic [ADDR_W-1:0]   write_reg_d;
  logic [WIDTH-1:0]    write_data_d, r0_d;
  logic [1:0]          reg_write_d;

  logic                wb_go;
  logic                wb_dbz;
  logic [ADDR_W-1:0]   wb_dest;
  logic [WIDTH-1:0]    wb_data, wb_r0;

  // One shift-add multiply step and one restoring divide step
  logic [WIDTH:0]      mul_sum;
  logic [WIDTH-1:0]    mul_hi, mul_lo;
  logic [WIDTH:0]      div_shift;
  logic                div_ge;
  logic [WIDTH-1:0]    div_diff, div_hi, div_lo;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : WIDTH'(0))};
    mul_hi    = mul_sum[WIDTH:1];
    mul_lo    = {mul_sum[0], lo_q[WIDTH-1:1]};
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, b_q};
    div_diff  = div_shift[WIDTH-1:0] - b_q;
    div_hi    = div_ge ? div_diff : div_shift[WIDTH-1:0];
    div_lo    = {lo_q[WIDTH-2:0], div_ge};
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    dest_d  = dest_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    wb_go   = 1'b0;
    wb_dbz  = 1'b0;
    wb_dest = dest_q;
    wb_data = '0;
    wb_r0   = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op;
          dest_d = dest;
          b_d    = op_b;
          if (op && (op_b == '0)) begin
            state_d = WB;
            wb_go   = 1'b1;
            wb_dbz  = 1'b1;
            wb_dest = dest;
            wb_data = '1;
            wb_r0   = op_a;
          end else begin
            state_d = RUN;
            count_d = CNT_W'(WIDTH - 1);
            hi_d    = '0;
            lo_d    = op_a;
          end
        end
      end
      RUN: begin
        hi_d    = op_q ? div_hi : mul_hi;
        lo_d    = op_q ? div_lo : mul_lo;
        count_d = count_q - CNT_W'(1);
        if (count_q == '0) begin
          state_d = WB;
          wb_go   = 1'b1;
          wb_data = lo_d;
          wb_r0   = hi_d;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d       = (state_d != IDLE);
    done_d       = wb_go;
    dbz_d        = wb_dbz;
    write_reg_d  = wb_go ? wb_dest : '0;
    write_data_d = wb_data;
    r0_d         = wb_r0;
    // R0 is written through its dedicated port only, never twice
    reg_write_d  = wb_go ? ((wb_dest == '0) ? 2'b01 : 2'b11) : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      op_q        <= 1'b0;
      dest_q      <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      write_reg   <= '0;
      write_data  <= '0;
      r0          <= '0;
      reg_write   <= 2'b00;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      op_q        <= op_d;
      dest_q      <= dest_d;
      b_q         <= b_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      busy        <= busy_d;
      done        <= done_d;
      div_by_zero <= dbz_d;
      write_reg   <= write_reg_d;
      write_data  <= write_data_d;
      r0          <= r0_d;
      reg_write   <= reg_write_d;
    end
  end

endmodule
